// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED shifter / fade-driver pipeline.
// Level width and full-scale derivation live here so both stages agree on brightness scale.
package led_pkg;

   localparam int NUM_LEDS        = 8;
   localparam int LEVEL_W_DEFAULT = 4;

   // What a channel does to its brightness level on the coming edge.
   typedef enum logic [1:0] {
      LVL_HOLD  = 2'd0,
      LVL_LIGHT = 2'd1,
      LVL_DECAY = 2'd2
   } level_op_e;

   function automatic int lvl_max(input int level_w);
      return (1 << level_w) - 1;
   endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED: brightness level register with light/decay priority, plus the PWM comparator
// and registered pin drive.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int LEVEL_W = LEVEL_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               lit,
   input  logic               step,
   input  logic               enable,
   input  logic [LEVEL_W-1:0] pwm_cnt,
   output logic               led_out,
   output logic               is_fading
);

   localparam logic [LEVEL_W-1:0] LVL_MAX = {LEVEL_W{1'b1}};

   level_op_e          level_op;
   logic [LEVEL_W-1:0] level_d, level_q;
   logic               led_out_d, led_out_q;

   // A lit bit (fresh strobe or held pattern) overrides any decay on the same edge.
   always_comb begin
      level_op = LVL_HOLD;
      if (lit) begin
         level_op = LVL_LIGHT;
      end else if (step && (level_q != '0)) begin
         level_op = LVL_DECAY;
      end

      level_d = level_q;
      unique case (level_op)
         LVL_LIGHT: level_d = LVL_MAX;
         LVL_DECAY: level_d = level_q - LEVEL_W'(1);
         default:   level_d = level_q;
      endcase

      led_out_d = enable && (level_q > pwm_cnt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level_q   <= '0;
         led_out_q <= 1'b0;
      end else begin
         level_q   <= level_d;
         led_out_q <= led_out_d;
      end
   end

   assign led_out   = led_out_q;
   assign is_fading = (level_q != '0) && (level_q != LVL_MAX);

endmodule

// File: rtl/led_fade_driver.sv
// Fade driver: turns the shifter's 8-bit pattern into PWM LED drive where cleared bits
// fade out stepwise, leaving a trail behind the rotating pattern.
module led_fade_driver
   import led_pkg::*;
#(
   parameter int LEVEL_W       = LEVEL_W_DEFAULT,
   parameter int DECAY_PERIODS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_LEDS-1:0] pattern_in,
   input  logic                pattern_valid,
   input  logic                enable,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                period_tick,
   output logic                fading
);

   localparam int                 DCNT_W     = (DECAY_PERIODS > 1) ? $clog2(DECAY_PERIODS) : 1;
   localparam logic [LEVEL_W-1:0] PWM_LAST   = LEVEL_W'(lvl_max(LEVEL_W) - 1);
   localparam logic [DCNT_W-1:0]  DECAY_LAST = DCNT_W'(DECAY_PERIODS - 1);

   logic [LEVEL_W-1:0]  pwm_cnt_d, pwm_cnt_q;
   logic [DCNT_W-1:0]   decay_cnt_d, decay_cnt_q;
   logic [NUM_LEDS-1:0] pattern_q_d, pattern_q_q;
   logic [NUM_LEDS-1:0] pattern_eff;
   logic                period_tick_d, period_tick_q;
   logic                fading_d, fading_q;
   logic                period_end;
   logic                step;
   logic [NUM_LEDS-1:0] chan_fading;

   // A strobe takes effect in its own cycle, so bits it clears can decay on a coincident step.
   always_comb begin
      period_end    = (pwm_cnt_q == PWM_LAST);
      step          = period_end && (decay_cnt_q == DECAY_LAST);
      pwm_cnt_d     = period_end ? '0 : pwm_cnt_q + LEVEL_W'(1);
      decay_cnt_d   = decay_cnt_q;
      if (step) begin
         decay_cnt_d = '0;
      end else if (period_end) begin
         decay_cnt_d = decay_cnt_q + DCNT_W'(1);
      end
      pattern_eff   = pattern_valid ? pattern_in : pattern_q_q;
      pattern_q_d   = pattern_eff;
      period_tick_d = period_end;
      fading_d      = |chan_fading;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt_q     <= '0;
         decay_cnt_q   <= '0;
         pattern_q_q   <= '0;
         period_tick_q <= 1'b0;
         fading_q      <= 1'b0;
      end else begin
         pwm_cnt_q     <= pwm_cnt_d;
         decay_cnt_q   <= decay_cnt_d;
         pattern_q_q   <= pattern_q_d;
         period_tick_q <= period_tick_d;
         fading_q      <= fading_d;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
      led_fade_channel #(
         .LEVEL_W (LEVEL_W)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .lit       (pattern_eff[i]),
         .step      (step),
         .enable    (enable),
         .pwm_cnt   (pwm_cnt_q),
         .led_out   (led_out[i]),
         .is_fading (chan_fading[i])
      );
   end

   assign period_tick = period_tick_q;
   assign fading      = fading_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver: a time-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_led_fade_driver;

   localparam int LVL_MAX = 15;
   localparam int DECAY   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pattern_in = 8'h00;
   logic       pattern_valid = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] led_out;
   logic       period_tick;
   logic       fading;

   int test_count = 0;
   int fail_count = 0;

   // Reference model state: edges since reset, latched pattern, per-LED levels.
   int         m_t = 0;
   logic [7:0] m_pat = 8'h00;
   int         m_level [8];
   logic       m_valid = 1'b0;
   logic [7:0] exp_led = 8'h00;
   logic       exp_tick = 1'b0;
   logic       exp_fading = 1'b0;

   led_fade_driver #(
      .LEVEL_W       (4),
      .DECAY_PERIODS (DECAY)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pattern_in    (pattern_in),
      .pattern_valid (pattern_valid),
      .enable        (enable),
      .led_out       (led_out),
      .period_tick   (period_tick),
      .fading        (fading)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      test_count++;
      if (actual != expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] pat);
      pattern_in    = pat;
      pattern_valid = 1'b1;
      @(negedge clk);
      pattern_valid = 1'b0;
   endtask

   // The PWM phase and decay steps follow from elapsed time since reset alone.
   always @(posedge clk) begin
      int  pwm;
      bit  pend;
      bit  stp;
      if (rst) begin
         m_t        = 0;
         m_pat      = 8'h00;
         for (int i = 0; i < 8; i++) m_level[i] = 0;
         exp_led    = 8'h00;
         exp_tick   = 1'b0;
         exp_fading = 1'b0;
         m_valid    = 1'b1;
      end else begin
         pwm        = m_t % LVL_MAX;
         pend       = (pwm == LVL_MAX - 1);
         stp        = pend && (((m_t / LVL_MAX) % DECAY) == DECAY - 1);
         exp_tick   = pend;
         exp_fading = 1'b0;
         for (int i = 0; i < 8; i++) begin
            exp_led[i] = enable && (m_level[i] > pwm);
            if (m_level[i] != 0 && m_level[i] != LVL_MAX) exp_fading = 1'b1;
         end
         if (pattern_valid) m_pat = pattern_in;
         for (int i = 0; i < 8; i++) begin
            if (m_pat[i]) m_level[i] = LVL_MAX;
            else if (stp && m_level[i] > 0) m_level[i] = m_level[i] - 1;
         end
         m_t++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checkOutput("model.led_out", int'(led_out), int'(exp_led));
         checkOutput("model.period_tick", int'(period_tick), int'(exp_tick));
         checkOutput("model.fading", int'(fading), int'(exp_fading));
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] pat;
      int         guard;

      // Case 1: reset, then idle for 100 cycles.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         checkOutput("idle.led_out", int'(led_out), 0);
         checkOutput("idle.fading", int'(fading), 0);
         checkOutput("idle.period_tick", int'(period_tick), (k % 15 == 0) ? 1 : 0);
      end

      // Case 2: strobe 0x01, LED0 on one edge after the level is loaded.
      applyStimulus(8'h01);
      @(negedge clk);
      checkOutput("lit.led_out", int'(led_out), 8'h01);
      checkOutput("lit.fading", int'(fading), 0);
      repeat (20) @(negedge clk);
      checkOutput("lit_hold.led_out", int'(led_out), 8'h01);

      // Case 4: strobe 0x02 exactly on a decay step edge.
      guard = 0;
      while ((m_t % (LVL_MAX * DECAY)) != (LVL_MAX * DECAY - 1) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("step_align.timeout", guard < 100 ? 1 : 0, 1);
      applyStimulus(8'h02);
      checkOutput("step_strobe.model_level0", m_level[0], 14);
      checkOutput("step_strobe.model_level1", m_level[1], 15);
      @(negedge clk);
      checkOutput("step_strobe.fading", int'(fading), 1);

      // Case 3 with case 5 embedded: clear everything, blank output mid-fade.
      applyStimulus(8'h00);
      repeat (100) @(negedge clk);
      checkOutput("fade_mid.fading", int'(fading), 1);
      enable = 1'b0;
      @(negedge clk);
      checkOutput("disable.led_out", int'(led_out), 0);
      repeat (39) @(negedge clk);
      enable = 1'b1;
      repeat (400) @(negedge clk);
      checkOutput("fade_done.led_out", int'(led_out), 0);
      checkOutput("fade_done.fading", int'(fading), 0);
      checkOutput("fade_done.model_level1", m_level[1], 0);

      // Case 6: fast rotating strobes, then reset mid-trail.
      pat = 8'h1F;
      for (int n = 0; n < 12; n++) begin
         applyStimulus(pat);
         @(negedge clk);
         pat = {pat[6:0], pat[7]};
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_trail.led_out", int'(led_out), 0);
      checkOutput("rst_trail.period_tick", int'(period_tick), 0);
      checkOutput("rst_trail.fading", int'(fading), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
